// File: rtl/button_bank.sv
// button_bank: N-channel push-button front end.
// Each channel runs a 2-flop synchroniser, a symmetric press/release debouncer
// and a pulse FSM (IDLE/PULSE/HOLD) with optional auto-repeat. A registered
// priority encoder reports the lowest channel that started a pulse each cycle.
// evt_valid/evt_idx is a one-cycle strobe with no ready: the consumer must take
// it the cycle it is high. evt_idx holds its last value while evt_valid is low.
// Per-channel FSM state is g_ch[i].state_q, a plain enum register for probing.
module button_bank #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_PERIOD = 1000000,
  parameter int PULSE_CYCLES    = 1,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000,
  localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] pulse,
  output logic             evt_valid,
  output logic [IW-1:0]    evt_idx
);

  localparam int CW   = $clog2(DEBOUNCE_PERIOD + 1);
  localparam int PW   = $clog2(PULSE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_PERIOD - 1);
  localparam logic [PW-1:0] PLEN_LAST = PW'(PULSE_CYCLES);
  localparam logic [TW-1:0] T_DELAY   = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] T_RATE    = TW'(REPEAT_RATE);
  localparam logic [TW-1:0] T_MAX     = TW'(TMAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } pstate_t;

  logic [N_BTN-1:0] pulse_start;
  logic [IW-1:0]    first_idx;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          lvl_nxt;
    pstate_t       state_q;
    logic [PW-1:0] plen;
    logic [TW-1:0] tmr;
    logic          first_rep;
    logic          pulse_q;
    logic          start_q;

    // Two-flop synchroniser for the raw asynchronous button.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= btn[i];
        s2 <= s1;
      end
    end

    // Debounced level for the next cycle; the FSM uses it to react the same edge.
    always_comb begin
      lvl_nxt = level_q;
      if ((s2 != level_q) && (cnt == CNT_LAST)) lvl_nxt = ~level_q;
    end

    // Debounce counter: any return to the stable value restarts the count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt     <= '0;
        level_q <= 1'b0;
      end else begin
        level_q <= lvl_nxt;
        if ((s2 == level_q) || (cnt == CNT_LAST)) cnt <= '0;
        else                                      cnt <= cnt + 1'b1;
      end
    end

    // Pulse FSM: fixed-length pulse per press, then optional repeat pulses while held.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= IDLE;
        pulse_q   <= 1'b0;
        start_q   <= 1'b0;
        plen      <= '0;
        tmr       <= '0;
        first_rep <= 1'b0;
      end else begin
        start_q <= 1'b0;
        // tmr saturates so it can never wrap while a button is held forever.
        if ((state_q != IDLE) && (tmr != T_MAX)) tmr <= tmr + 1'b1;
        case (state_q)
          IDLE: begin
            if (lvl_nxt && !level_q) begin
              state_q   <= PULSE;
              pulse_q   <= 1'b1;
              start_q   <= 1'b1;
              plen      <= PW'(1);
              tmr       <= TW'(1);
              first_rep <= 1'b1;
            end
          end
          PULSE: begin
            // A pulse always runs its full length, even if the level drops.
            if (plen == PLEN_LAST) begin
              pulse_q <= 1'b0;
              state_q <= lvl_nxt ? HOLD : IDLE;
            end else begin
              plen <= plen + 1'b1;
            end
          end
          HOLD: begin
            if (!lvl_nxt) begin
              state_q <= IDLE;
            end else if ((REPEAT_EN != 0) && (tmr >= (first_rep ? T_DELAY : T_RATE))) begin
              state_q   <= PULSE;
              pulse_q   <= 1'b1;
              start_q   <= 1'b1;
              plen      <= PW'(1);
              tmr       <= TW'(1);
              first_rep <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign level[i]       = level_q;
    assign pulse[i]       = pulse_q;
    assign pulse_start[i] = start_q;
  end

  // Lowest-numbered channel starting a pulse wins.
  always_comb begin
    first_idx = '0;
    for (int j = N_BTN - 1; j >= 0; j--) begin
      if (pulse_start[j]) first_idx = IW'(j);
    end
  end

  // Registered event strobe; index is held between events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_idx   <= '0;
    end else begin
      evt_valid <= |pulse_start;
      if (|pulse_start) evt_idx <= first_idx;
    end
  end

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank: three instances cover the base press path,
// auto-repeat, and a 3-cycle pulse. All expected values are hand-computed
// cycle numbers counted from the first edge that samples the new btn value.
module tb_button_bank;

  logic clk = 1'b0;
  logic rst;

  logic [3:0] btn_b, lvl_b, pul_b;
  logic       ev_b;
  logic [1:0] idx_b;
  logic [3:0] btn_r, lvl_r, pul_r;
  logic       ev_r;
  logic [1:0] idx_r;
  logic [3:0] btn_s, lvl_s, pul_s;
  logic       ev_s;
  logic [1:0] idx_s;

  int n_vec = 0;
  int n_err = 0;

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  button_bank #(.N_BTN(4), .DEBOUNCE_PERIOD(4), .PULSE_CYCLES(2), .REPEAT_EN(0),
                .REPEAT_DELAY(10), .REPEAT_RATE(5)) u_base (
    .clk(clk), .rst(rst), .btn(btn_b), .level(lvl_b), .pulse(pul_b),
    .evt_valid(ev_b), .evt_idx(idx_b));

  button_bank #(.N_BTN(4), .DEBOUNCE_PERIOD(4), .PULSE_CYCLES(2), .REPEAT_EN(1),
                .REPEAT_DELAY(10), .REPEAT_RATE(5)) u_rep (
    .clk(clk), .rst(rst), .btn(btn_r), .level(lvl_r), .pulse(pul_r),
    .evt_valid(ev_r), .evt_idx(idx_r));

  button_bank #(.N_BTN(4), .DEBOUNCE_PERIOD(4), .PULSE_CYCLES(3), .REPEAT_EN(0),
                .REPEAT_DELAY(10), .REPEAT_RATE(5)) u_short (
    .clk(clk), .rst(rst), .btn(btn_s), .level(lvl_s), .pulse(pul_s),
    .evt_valid(ev_s), .evt_idx(idx_s));

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [63:0] rep_starts;
  logic        exp_p, exp_e, exp_l;

  initial begin
    rst   = 1'b1;
    btn_b = 4'b0;
    btn_r = 4'b0;
    btn_s = 4'b0;
    repeat (3) tick();

    // Reset state
    check("rst_lvl_b", lvl_b, 4'b0);
    check("rst_pul_b", pul_b, 4'b0);
    check("rst_ev_b", ev_b, 1'b0);
    check("rst_idx_b", idx_b, 2'd0);
    check("rst_pul_r", pul_r, 4'b0);
    check("rst_pul_s", pul_s, 4'b0);
    rst = 1'b0;
    tick();
    check("post_rst_lvl_b", lvl_b, 4'b0);

    // Clean press on btn[2], held 20 sampled cycles
    btn_b = 4'b0100;
    for (int t = 1; t <= 20; t++) begin
      tick();
      check("press_lvl", lvl_b, (t >= 6) ? 4'b0100 : 4'b0000);
      check("press_pul", pul_b, (t == 6 || t == 7) ? 4'b0100 : 4'b0000);
      check("press_ev", ev_b, (t == 7) ? 1'b1 : 1'b0);
      if (t >= 7) check("press_idx", idx_b, 2'd2);
    end
    btn_b = 4'b0000;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check("release_lvl", lvl_b, (t < 6) ? 4'b0100 : 4'b0000);
      check("release_pul", pul_b, 4'b0000);
      check("release_ev", ev_b, 1'b0);
    end

    // Bounce on btn[0]: 3 high / 1 low, four times, then a steady hold
    for (int r = 0; r < 4; r++) begin
      for (int ph = 0; ph < 4; ph++) begin
        btn_b = (ph < 3) ? 4'b0001 : 4'b0000;
        tick();
        check("bounce_lvl", lvl_b, 4'b0000);
        check("bounce_pul", pul_b, 4'b0000);
      end
    end
    btn_b = 4'b0001;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check("bhold_lvl", lvl_b, (t >= 6) ? 4'b0001 : 4'b0000);
      check("bhold_pul", pul_b, (t == 6 || t == 7) ? 4'b0001 : 4'b0000);
      check("bhold_ev", ev_b, (t == 7) ? 1'b1 : 1'b0);
      if (t == 7) check("bhold_idx", idx_b, 2'd0);
    end
    btn_b = 4'b0000;
    repeat (10) tick();
    check("bounce_rel_lvl", lvl_b, 4'b0000);

    // Simultaneous press on btn[1] and btn[3]
    btn_b = 4'b1010;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check("sim_pul", pul_b, (t == 6 || t == 7) ? 4'b1010 : 4'b0000);
      check("sim_ev", ev_b, (t == 7) ? 1'b1 : 1'b0);
      if (t >= 7) check("sim_idx", idx_b, 2'd1);
    end
    check("sim_lvl", lvl_b, 4'b1010);
    btn_b = 4'b0000;
    repeat (10) tick();
    check("sim_rel_lvl", lvl_b, 4'b0000);
    check("sim_idx_hold", idx_b, 2'd1);

    // Auto-repeat: btn[0] held 40 sampled cycles; starts at 6,16,21,26,31,36,41
    rep_starts = '0;
    rep_starts[6]  = 1'b1;
    rep_starts[16] = 1'b1;
    rep_starts[21] = 1'b1;
    rep_starts[26] = 1'b1;
    rep_starts[31] = 1'b1;
    rep_starts[36] = 1'b1;
    rep_starts[41] = 1'b1;
    btn_r = 4'b0001;
    for (int t = 1; t <= 55; t++) begin
      tick();
      exp_p = rep_starts[t] | rep_starts[t-1];
      exp_e = rep_starts[t-1];
      exp_l = (t >= 6) && (t < 46);
      check("rep_pul", pul_r, {3'b000, exp_p});
      check("rep_ev", ev_r, exp_e);
      check("rep_lvl", lvl_r, {3'b000, exp_l});
      if (exp_e) check("rep_idx", idx_r, 2'd0);
      if (t == 40) btn_r = 4'b0000;
    end

    // Short press with 3-cycle pulse: release sampled one edge after level rises
    btn_s = 4'b0001;
    for (int t = 1; t <= 24; t++) begin
      tick();
      check("short_pul", pul_s, (t >= 6 && t <= 8) ? 4'b0001 : 4'b0000);
      check("short_lvl", lvl_s, (t >= 6 && t <= 11) ? 4'b0001 : 4'b0000);
      check("short_ev", ev_s, (t == 7) ? 1'b1 : 1'b0);
      if (t == 6) btn_s = 4'b0000;
    end

    // Reset during the debounce count
    btn_b = 4'b0100;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("rst_cnt_lvl", lvl_b, 4'b0000);
    check("rst_cnt_ev", ev_b, 1'b0);
    check("rst_cnt_idx", idx_b, 2'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      check("rr1_lvl", lvl_b, (t >= 6) ? 4'b0100 : 4'b0000);
      check("rr1_pul", pul_b, (t >= 6) ? 4'b0100 : 4'b0000);
    end

    // Reset during a pulse; button still held through release
    rst = 1'b1;
    #1;
    check("rst_pul_pul", pul_b, 4'b0000);
    check("rst_pul_lvl", lvl_b, 4'b0000);
    check("rst_pul_ev", ev_b, 1'b0);
    tick();
    rst = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check("rr2_lvl", lvl_b, (t >= 6) ? 4'b0100 : 4'b0000);
      check("rr2_pul", pul_b, (t == 6 || t == 7) ? 4'b0100 : 4'b0000);
      check("rr2_ev", ev_b, (t == 7) ? 1'b1 : 1'b0);
      if (t == 7) check("rr2_idx", idx_b, 2'd2);
    end
    btn_b = 4'b0000;
    repeat (10) tick();

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_bank.md
Name: button_bank

Overview:
- Parametrised multi-channel debouncer for N push-buttons.
- Per channel:
  - 2-flop synchroniser.
  - Symmetric press/release debounce.
  - Press pulse of programmable length.
  - Optional auto-repeat while the button is held.
- Adds a priority-encoded single-event output so game control logic can consume one direction per cycle.
- Sits between board buttons and the game FSM; replaces per-button instances of the older single-channel debouncer.

Parameters:
- N_BTN, 4, number of button channels (1..16).
- DEBOUNCE_PERIOD, 1000000, consecutive stable cycles required to accept a level change (>=1).
- PULSE_CYCLES, 1, length of each press pulse in cycles (>=1).
- REPEAT_EN, 0, 1 enables auto-repeat pulses while held.
- REPEAT_DELAY, 50000000, cycles from the first pulse start to the first repeat pulse start (> PULSE_CYCLES).
- REPEAT_RATE, 10000000, cycles between successive repeat pulse starts (> PULSE_CYCLES).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- btn  in  N_BTN  raw asynchronous button inputs, active high.
- level  out  N_BTN  debounced button state.
- pulse  out  N_BTN  press pulses; one train per channel.
- evt_valid  out  1  one-cycle strobe: at least one channel started a pulse this cycle.
- evt_idx  out  clog2(N_BTN) (min 1)  index of the lowest-numbered channel that started a pulse this cycle.

Behaviour:
- Reset (async assert, sync release):
  - level, pulse, evt_valid, evt_idx = 0.
  - Synchroniser flops, counters and stable state cleared.
- Synchroniser: btn[i] passes through 2 flops to give s[i]; 2-cycle latency.
- Debounce, per channel:
  - Counter cnt[i] of width clog2(DEBOUNCE_PERIOD+1).
  - If s[i] == level[i]: cnt <= 0.
  - Else if cnt == DEBOUNCE_PERIOD-1: level[i] toggles, cnt <= 0.
  - Else: cnt increments.
  - Any glitch back to the stable value restarts the count.
  - Release is debounced identically.
- Latency: btn held high from edge k makes level rise at edge k+2+DEBOUNCE_PERIOD-1. With DEBOUNCE_PERIOD=4, level is high in the 6th cycle after btn is first sampled.
- Pulse FSM per channel, states IDLE, PULSE, HOLD:
  - IDLE -> PULSE on the cycle level rises. pulse[i] asserts that same cycle; plen <= 1; tmr <= 1.
  - PULSE: pulse stays high until PULSE_CYCLES cycles have elapsed, then -> HOLD with pulse low. If level falls, pulse still completes its full length, then -> IDLE.
  - HOLD:
    - If level falls -> IDLE.
    - Else if REPEAT_EN and tmr reaches the threshold -> PULSE with tmr <= 1.
    - Threshold is REPEAT_DELAY for the first repeat after a press, REPEAT_RATE for later repeats.
  - tmr counts every cycle outside IDLE. Width is clog2(max(REPEAT_DELAY, REPEAT_RATE)+1); it must not wrap.
  - REPEAT_EN=0: exactly one pulse per debounced press; tmr may be omitted.
- Pulse start: pulse_start[i] is high in the first cycle of each pulse, for both press and repeat pulses.
- Event encoder (registered, 1-cycle latency after pulse_start):
  - evt_valid <= |pulse_start.
  - evt_idx <= lowest i with pulse_start[i].
  - Simultaneous starts on other channels are not reported on evt; they still appear on pulse.
  - evt_idx holds its last value when evt_valid is 0.
- Reset mid-press: all state clears. A button still held after release from reset re-debounces and produces a new press pulse.

Test Plan (DEBOUNCE_PERIOD=4, PULSE_CYCLES=2, N_BTN=4 unless stated):
- Clean press on btn[2] held 20 cycles:
  - level[2] high in the 6th cycle after first sample.
  - pulse[2] high for exactly 2 cycles starting the same cycle.
  - evt_valid=1 with evt_idx=2 one cycle later.
  - level[2] falls 6 cycles after release; no extra pulse.
- Bounce: btn[0] toggles high 3 cycles / low 1 cycle repeatedly, then holds high. No level/pulse during the bounce; a single press is accepted 4 stable cycles after the hold begins.
- Simultaneous: btn[1] and btn[3] rise on the same edge. pulse[1] and pulse[3] rise together; a single evt_valid with evt_idx=1.
- Auto-repeat (REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_RATE=5), btn[0] held 40 cycles: pulse starts at t0, t0+10, t0+15, t0+20, … until release; each pulse is 2 cycles long and each start produces an evt.
- Short press: btn held long enough to set level, released 1 cycle after level rises (PULSE_CYCLES=3). Pulse completes its full 3 cycles, then the FSM returns to IDLE; no repeat.
- Reset mid-operation: assert rst during the debounce count and during a pulse. Outputs go to 0 asynchronously. With btn held through reset release, a fresh press appears 2+DEBOUNCE_PERIOD cycles after release.
